// File: rtl/control_seq.sv
// control_seq: clocked CPU control sequencer.
// Latches one instruction at a time through a valid/ready handshake, runs
// it for one or two cycles, holds memory strobes until mem_ack, and raises
// a sticky err when the memory never answers.
// Optional: define CTRL_STALL_CNT_EN to add the 16-bit saturating stall_cnt.
module control_seq #(
    parameter int RS_W     = 2,
    parameter int ALU_W    = 4,   // must be <= 5
    parameter int WAIT_MAX = 15   // must be >= 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       inst_in,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic             carry,
    input  logic             mem_ack,
    output logic             M,
    output logic             MW,
    output logic             MC,
    output logic             J,
    output logic             LJ,
    output logic             CLI,
    output logic             LJR,
    output logic             RD,
    output logic             WR,
    output logic             WA,
    output logic             WC,
    output logic             S,
    output logic             Y,
    output logic [RS_W-1:0]  RS,
    output logic [ALU_W-1:0] ALU,
    output logic             cyc,
    output logic             busy,
    output logic             err
`ifdef CTRL_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {IDLE, C0, C1, ERR} state_t;

    state_t           state, state_d;
    logic [7:0]       ir;
    logic [CNT_W-1:0] wait_cnt;

    logic simple, jtype, mtype, alur, alui, alu_wr;
    logic in_c0, in_c1, mem_wait, done, timeout, accept;

    // Instruction decode, handshake and control strobes.
    always_comb begin
        simple   = (ir[7:5] == 3'b000);
        jtype    = (ir[7:5] == 3'b111);
        mtype    = (ir[7:6] == 2'b10);
        alur     = (ir[7:6] == 2'b01);
        alui     = (ir[7:5] == 3'b110);
        in_c0    = (state == C0);
        in_c1    = (state == C1);
        alu_wr   = alur | (alui & in_c1);

        MC       = in_c0 & ir[7];
        M        = in_c1 & mtype;
        MW       = M & ir[5];
        mem_wait = MC | M;

        // Last cycle of the held instruction; one-shot strobes fire only here.
        done     = (in_c0 & ~ir[7]) | (in_c1 & (~mtype | mem_ack));
        timeout  = mem_wait & ~mem_ack & (wait_cnt == CNT_W'(WAIT_MAX - 1));

        // Gated by rst_n so the fetch side sees "not ready" for the whole reset.
        inst_ready = rst_n & ((state == IDLE) | done);
        accept     = inst_valid & inst_ready;

        LJ  = done & simple & ir[4] & ~ir[3];
        CLI = LJ & ir[1];
        LJR = LJ & ir[2];
        RD  = done & simple & ~ir[4] & ir[2];
        WR  = done & simple & ~ir[4] & ir[3];
        J   = done & jtype & in_c1 & ~(ir[4] & carry);
        WA  = done & ((mtype & ~ir[5]) | (alu_wr & ~(ir[4] & ~ir[3])));
        WC  = alu_wr & WA;

        S    = ir[4];
        Y    = ir[5];
        RS   = ir[RS_W-1:0];
        ALU  = ir[ALU_W-1:0];
        cyc  = in_c1;
        busy = in_c0 | in_c1;
    end

    // Next-state selection.
    always_comb begin
        // NOTE: default assigned first so every path drives state_d and no latch is inferred.
        state_d = state;
        unique case (state)
            IDLE: if (accept) state_d = C0;
            C0: begin
                if (ir[7]) begin
                    if (timeout)      state_d = ERR;
                    else if (mem_ack) state_d = C1;
                end else begin
                    state_d = accept ? C0 : IDLE;
                end
            end
            C1: begin
                if (timeout)   state_d = ERR;
                else if (done) state_d = accept ? C0 : IDLE;
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    // State, instruction register, wait counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ir       <= 8'h00;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here updates from pre-edge values.
            state <= state_d;
            if (accept) ir <= inst_in;
            if (accept)
                wait_cnt <= '0;
            else if (mem_wait)
                wait_cnt <= mem_ack ? '0 : wait_cnt + CNT_W'(1);
            if (timeout) err <= 1'b1;
        end
    end

`ifdef CTRL_STALL_CNT_EN
    // Saturating count of every cycle a memory strobe waits without ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= 16'h0000;
        else if (mem_wait & ~mem_ack & (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'h0001;
    end
`endif

endmodule
